// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC fetch unit.
// MISALIGN_TRAP_EN adds the HALT state used for misaligned-redirect trapping.
package pc_fetch_unit_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [ADDR_W-1:0]  PC_INC     = 32'd4;
  localparam logic [ADDR_W-1:0]  ALIGN_MASK = 32'h0000_0003;

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DROP  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_t;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry buffer catching a fetch accepted while IF/ID is stalled.
// Behaviour is identical with or without MISALIGN_TRAP_EN.
module fetch_hold_buffer
  import pc_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t push_entry,
  output logic         full,
  output fetch_entry_t entry
);

  // clear (redirect) wins; push and pop never coincide since a full buffer blocks requests
  always_ff @(posedge clk or negedge reset_n) begin : hold_reg
    if (!reset_n) begin
      full        <= 1'b0;
      entry.addr  <= '0;
      entry.instr <= NOP_INSTR;
    end else if (clear) begin
      full <= 1'b0;
    end else if (push) begin
      full  <= 1'b1;
      entry <= push_entry;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC sequencing, imem handshake, redirect and stall handling.
// Define MISALIGN_TRAP_EN to trap misaligned redirects (HALT + fetch_misalign).
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               branch_select,
  input  logic [ADDR_W-1:0]  target_address,
  input  logic               stall,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               flush
`ifdef MISALIGN_TRAP_EN
  ,
  output logic               fetch_misalign
`endif
);

  fetch_state_t       state, state_next;
  logic [ADDR_W-1:0]  pc, pc_next;
  logic [ADDR_W-1:0]  target;
  logic               accept, pending, redirect;
  logic               req_next, if_valid_next;
  logic [ADDR_W-1:0]  addr_next, if_pc_next;
  logic [INSTR_W-1:0] if_instr_next;
  logic               buf_push, buf_pop, buf_clear, buf_full;
  fetch_entry_t       buf_in, buf_entry;

  assign accept  = imem_req & imem_ready;
  assign pending = imem_req & ~imem_ready;
  assign target  = target_address & ~ALIGN_MASK;
  assign flush   = branch_select;
  assign buf_in.addr  = imem_addr;
  assign buf_in.instr = imem_instr;

`ifdef MISALIGN_TRAP_EN
  logic misaligned, misalign_next;
  assign misaligned = |(target_address & ALIGN_MASK);
  // HALT ignores further redirects until reset
  assign redirect   = branch_select & (state != ST_HALT);
`else
  assign redirect   = branch_select;
`endif

  always_ff @(posedge clk or negedge reset_n) begin : state_reg
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin : next_state_logic
    state_next = state;
    case (state)
      ST_IDLE:  state_next = ST_FETCH;
      ST_FETCH: if (redirect && pending) state_next = ST_DROP;
      ST_DROP:  if (imem_ready) state_next = ST_FETCH;
`ifdef MISALIGN_TRAP_EN
      ST_HALT:  state_next = ST_HALT;
`endif
      default:  state_next = ST_IDLE;
    endcase
`ifdef MISALIGN_TRAP_EN
    if (redirect && misaligned) state_next = ST_HALT;
`endif
  end

  always_comb begin : output_logic
    pc_next       = pc;
    req_next      = imem_req;
    addr_next     = imem_addr;
    if_valid_next = if_valid;
    if_pc_next    = if_pc;
    if_instr_next = if_instr;
    buf_push      = 1'b0;
    buf_pop       = 1'b0;
    buf_clear     = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misalign_next = fetch_misalign;
`endif
    case (state)
      ST_IDLE: begin
        req_next  = 1'b1;
        addr_next = pc;
      end
      ST_FETCH: begin
        if (accept) begin
          pc_next = pc + PC_INC;
          if (stall) begin
            buf_push = 1'b1;
            req_next = 1'b0;
          end else begin
            if_valid_next = 1'b1;
            if_pc_next    = imem_addr;
            if_instr_next = imem_instr;
            addr_next     = pc + PC_INC;
          end
        end else if (!stall) begin
          if (buf_full) begin
            if_valid_next = 1'b1;
            if_pc_next    = buf_entry.addr;
            if_instr_next = buf_entry.instr;
            buf_pop       = 1'b1;
            req_next      = 1'b1;
            addr_next     = pc;
          end else begin
            if_valid_next = 1'b0;
          end
        end
      end
      ST_DROP: begin
        // the stale word returns here and is thrown away
        if_valid_next = 1'b0;
        if (imem_ready) addr_next = pc;
      end
`ifdef MISALIGN_TRAP_EN
      ST_HALT: begin
        req_next      = 1'b0;
        if_valid_next = 1'b0;
      end
`endif
      default: ;
    endcase
    // redirect overrides stall and any accept in the same cycle
    if (redirect) begin
      pc_next       = target;
      if_valid_next = 1'b0;
      if_pc_next    = if_pc;
      if_instr_next = if_instr;
      buf_push      = 1'b0;
      buf_pop       = 1'b0;
      buf_clear     = 1'b1;
      req_next      = 1'b1;
      addr_next     = pending ? imem_addr : target;
`ifdef MISALIGN_TRAP_EN
      if (misaligned) begin
        req_next      = 1'b0;
        addr_next     = imem_addr;
        misalign_next = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : fetch_regs
    if (!reset_n) begin
      pc        <= RESET_VECTOR;
      imem_req  <= 1'b0;
      imem_addr <= RESET_VECTOR;
      if_valid  <= 1'b0;
      if_pc     <= '0;
      if_instr  <= NOP_INSTR;
    end else begin
      pc        <= pc_next;
      imem_req  <= req_next;
      imem_addr <= addr_next;
      if_valid  <= if_valid_next;
      if_pc     <= if_pc_next;
      if_instr  <= if_instr_next;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset_n) begin : misalign_reg
    if (!reset_n) fetch_misalign <= 1'b0;
    else          fetch_misalign <= misalign_next;
  end
`endif

  fetch_hold_buffer u_hold (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (buf_push),
    .pop        (buf_pop),
    .clear      (buf_clear),
    .push_entry (buf_in),
    .full       (buf_full),
    .entry      (buf_entry)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus random traffic
// against a transaction-level model; MISALIGN_TRAP_EN selects the trapping build.
module tb_pc_fetch_unit;

  localparam logic [31:0] RV  = 32'h0000_0080;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        branch_select = 1'b0;
  logic [31:0] target_address = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_instr = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        flush;
`ifdef MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pc_fetch_unit #(.RESET_VECTOR(RV)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .branch_select  (branch_select),
    .target_address (target_address),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_instr     (imem_instr),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .flush          (flush)
`ifdef MISALIGN_TRAP_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: what the fetch stage should expose after each edge
  typedef enum int {M_IDLE, M_FETCH, M_DROP, M_HALT} phase_e;
  phase_e      m_ph;
  bit          m_req, m_ifv, m_bfull, m_mis;
  logic [31:0] m_pc, m_addr, m_ifpc, m_ifinstr, m_baddr, m_binstr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = M_IDLE; m_pc = RV; m_addr = RV; m_req = 0; m_ifv = 0;
    m_ifpc = '0; m_ifinstr = NOP; m_bfull = 0; m_mis = 0;
    m_baddr = '0; m_binstr = NOP;
  endtask

  task automatic model_edge(input bit br, input logic [31:0] tgt, input bit st, input bit rdy);
    bit took;
    took = m_req && rdy;
    if (m_ph == M_HALT) return;
    if (br) begin
`ifdef MISALIGN_TRAP_EN
      if (tgt[1:0] != 2'b00) begin
        m_ph = M_HALT; m_req = 0; m_ifv = 0; m_mis = 1; m_bfull = 0;
        return;
      end
`endif
      m_pc = {tgt[31:2], 2'b00};
      m_ifv = 0; m_bfull = 0;
      if (m_req && !rdy) m_ph = M_DROP;  // old request still outstanding
      else begin m_ph = M_FETCH; m_req = 1; m_addr = m_pc; end
      return;
    end
    case (m_ph)
      M_IDLE: begin m_ph = M_FETCH; m_req = 1; m_addr = m_pc; end
      M_DROP: if (rdy) begin m_ph = M_FETCH; m_addr = m_pc; end
      M_FETCH: begin
        if (took) begin
          m_pc = m_pc + 32'd4;
          if (st) begin
            m_bfull = 1; m_baddr = m_addr; m_binstr = mem_word(m_addr); m_req = 0;
          end else begin
            m_ifv = 1; m_ifpc = m_addr; m_ifinstr = mem_word(m_addr); m_addr = m_pc;
          end
        end else if (!st) begin
          if (m_bfull) begin
            m_ifv = 1; m_ifpc = m_baddr; m_ifinstr = m_binstr; m_bfull = 0;
            m_req = 1; m_addr = m_pc;
          end else m_ifv = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".imem_req"},  32'(imem_req),  32'(m_req));
    check_eq({tag, ".imem_addr"}, imem_addr,      m_addr);
    check_eq({tag, ".if_valid"},  32'(if_valid),  32'(m_ifv));
    check_eq({tag, ".if_pc"},     if_pc,          m_ifpc);
    check_eq({tag, ".if_instr"},  if_instr,       m_ifinstr);
`ifdef MISALIGN_TRAP_EN
    check_eq({tag, ".misalign"},  32'(fetch_misalign), 32'(m_mis));
`endif
  endtask

  // Called just after a rising edge; applies inputs, checks flush, then the next edge
  task automatic step(input bit br, input logic [31:0] tgt, input bit st, input bit rdy);
    branch_select = br; target_address = tgt; stall = st; imem_ready = rdy;
    imem_instr = mem_word(m_addr);
    #1;
    check_eq("flush", 32'(flush), 32'(br));
    model_edge(br, tgt, st, rdy);
    @(posedge clk); #1;
    check_outputs("cyc");
  endtask

  task automatic do_reset();
    reset_n = 1'b0; branch_select = 0; stall = 0; imem_ready = 0;
    target_address = '0; imem_instr = '0;
    #1;
    model_reset();
    check_outputs("rst_async");
    @(posedge clk); #1;
    check_outputs("rst_hold");
    reset_n = 1'b1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [31:0] t;
    @(posedge clk); #1;
    do_reset();

    // reset release with zero-wait memory
    step(0, '0, 0, 1);
    check_eq("r035_addr0", imem_addr, RV);
    check_eq("r035_ifv0",  32'(if_valid), 32'd0);
    step(0, '0, 0, 1);
    check_eq("r035_addr1", imem_addr, RV + 32'd4);
    check_eq("r035_ifpc1", if_pc, RV);
    step(0, '0, 0, 1);
    check_eq("r035_addr2", imem_addr, RV + 32'd8);
    check_eq("r035_ifpc2", if_pc, RV + 32'd4);

    // three-cycle stall with the fetch at 0x10
    step(1, 32'h10, 0, 1);
    check_eq("r036_addr", imem_addr, 32'h10);
    step(0, '0, 1, 1);
    step(0, '0, 1, 1);
    step(0, '0, 1, 1);
    check_eq("r036_req_off", 32'(imem_req), 32'd0);
    check_eq("r036_ifv_frozen", 32'(if_valid), 32'd0);
    step(0, '0, 0, 1);
    check_eq("r036_ifpc_a", if_pc, 32'h10);
    check_eq("r036_instr_a", if_instr, mem_word(32'h10));
    step(0, '0, 0, 1);
    check_eq("r036_ifpc_b", if_pc, 32'h14);

    // redirect during an accept
    step(1, 32'h100, 0, 1);
    check_eq("r037_ifv", 32'(if_valid), 32'd0);
    check_eq("r037_addr", imem_addr, 32'h100);

    // redirect with the request pending
    step(0, '0, 0, 1);
    step(1, 32'h200, 0, 0);
    check_eq("r038_addr_hold", imem_addr, 32'h104);
    step(0, '0, 0, 0);
    check_eq("r038_ifv", 32'(if_valid), 32'd0);
    step(0, '0, 0, 1);
    check_eq("r038_addr_new", imem_addr, 32'h200);
    check_eq("r038_ifv2", 32'(if_valid), 32'd0);
    step(0, '0, 0, 1);
    check_eq("r038_ifpc", if_pc, 32'h200);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      if (i % 600 == 599) begin
        do_reset();
      end else begin
        t = $urandom;
`ifdef MISALIGN_TRAP_EN
        t[1:0] = 2'b00;
`endif
        step($urandom_range(0, 11) == 0, t, $urandom_range(0, 3) == 0,
             $urandom_range(0, 2) != 0);
      end
    end

    // misaligned redirect
    step(0, '0, 0, 1);
    step(1, 32'h102, 0, 1);
`ifdef MISALIGN_TRAP_EN
    check_eq("r039_misalign", 32'(fetch_misalign), 32'd1);
    check_eq("r039_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < 4; i++) step(i == 1, 32'h40, 0, 1);
    check_eq("r039_misalign_held", 32'(fetch_misalign), 32'd1);
`else
    check_eq("r039_addr", imem_addr, 32'h100);
`endif

    // reset asserted mid-DROP
    do_reset();
    step(0, '0, 0, 1);
    step(1, 32'h300, 0, 0);
    step(0, '0, 0, 0);
    reset_n = 1'b0;
    #1;
    check_eq("r040_req",   32'(imem_req), 32'd0);
    check_eq("r040_addr",  imem_addr, RV);
    check_eq("r040_ifv",   32'(if_valid), 32'd0);
    check_eq("r040_ifpc",  if_pc, 32'd0);
    check_eq("r040_instr", if_instr, NOP);
    @(posedge clk); #1;
    model_reset();
    reset_n = 1'b1;
    step(0, '0, 0, 1);
    check_eq("r040_first_addr", imem_addr, RV);
    check_eq("r040_first_req", 32'(imem_req), 32'd1);
    step(0, '0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
